// File: rtl/wave_read_scheduler.sv
// Wave-table BRAM read-port scheduler: per-tick oscillator burst, viz/dbg fill.
// Ports: clk_in/rst_in, tick + osc inputs, frame out, viz/dbg req/resp, BRAM port, status.
module wave_read_scheduler #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 14,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  sample_tick_in,
  input  logic [WW_WIDTH-1:0]                   wave_width_in,
  input  logic [NUM_OSCILLATORS-1:0]            osc_is_on_in,
  input  logic [NUM_OSCILLATORS*WW_WIDTH-1:0]   osc_index_in,
  output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_out,
  output logic                                  frame_valid_out,
  input  logic                                  viz_req_in,
  input  logic [WW_WIDTH-1:0]                   viz_index_in,
  output logic                                  viz_valid_out,
  output logic [SAMPLE_WIDTH-1:0]               viz_data_out,
  input  logic                                  dbg_req_in,
  input  logic [WW_WIDTH-1:0]                   dbg_index_in,
  output logic                                  dbg_valid_out,
  output logic [SAMPLE_WIDTH-1:0]               dbg_data_out,
  output logic [WW_WIDTH-1:0]                   bram_addr_out,
  output logic                                  bram_rd_en_out,
  input  logic [SAMPLE_WIDTH-1:0]               bram_data_in,
  output logic                                  busy_out,
  output logic                                  overrun_out
);

  localparam int N  = NUM_OSCILLATORS;
  localparam int SW = SAMPLE_WIDTH;
  localparam int WW = WW_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam int CW = $clog2(N + RL + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RL - 1);
  localparam logic [CW-1:0] AUX_LAST   = CW'(RL);

  typedef enum logic [1:0] {
    IDLE, OSC_ISSUE, OSC_DRAIN, AUX_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            tick_pending;
  logic            prefer_dbg;
  logic            aux_dbg;
  logic            take_tick, tick_drop;
  logic            grant, grant_dbg;
  logic            osc_issue, aux_issue, aux_done;
  logic            osc_on;
  logic [WW-1:0]   osc_idx, cur_addr, addr_q;
  logic            pipe_v    [RL];
  logic            pipe_on   [RL];
  logic [CW-1:0]   pipe_slot [RL];
  logic [SW-1:0]   shadow    [N];
  logic [SW-1:0]   cap_data;
  logic            publish;
  logic [N*SW-1:0] frame_nxt;

  always_comb begin
    osc_idx = '0;
    osc_on  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        osc_idx = osc_index_in[i*WW +: WW];
        osc_on  = osc_is_on_in[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_tick = 1'b0;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    osc_issue = 1'b0;
    aux_issue = 1'b0;
    aux_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_tick_in || tick_pending) begin
          take_tick = 1'b1;
          state_nxt = OSC_ISSUE;
          cnt_nxt   = '0;
        end else if (viz_req_in || dbg_req_in) begin
          grant     = 1'b1;
          grant_dbg = dbg_req_in && (!viz_req_in || prefer_dbg);
          state_nxt = AUX_WAIT;
          cnt_nxt   = '0;
        end
      end
      OSC_ISSUE: begin
        osc_issue = 1'b1;
        if (cnt == SLOT_LAST) begin
          state_nxt = OSC_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      OSC_DRAIN: begin
        if (cnt == DRAIN_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt + 1'b1;
      end
      AUX_WAIT: begin
        aux_issue = (cnt == '0);
        if (cnt == AUX_LAST) begin
          aux_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ticks are only lost when one is already waiting or a burst is running.
  assign tick_drop = sample_tick_in &&
    (tick_pending || state == OSC_ISSUE || state == OSC_DRAIN);

  // Out-of-range oscillator indices read sample 0.
  assign cur_addr = osc_issue
    ? ((osc_idx >= wave_width_in) ? '0 : osc_idx)
    : (aux_dbg ? dbg_index_in : viz_index_in);

  assign bram_rd_en_out = (osc_issue && osc_on) || aux_issue;
  assign bram_addr_out  = bram_rd_en_out ? cur_addr : addr_q;
  assign busy_out       = (state != IDLE);

  assign cap_data = pipe_on[RL-1] ? bram_data_in : '0;
  assign publish  = pipe_v[RL-1] && (pipe_slot[RL-1] == SLOT_LAST);

  // The last slot's data bypasses the shadow so the frame lands on time.
  always_comb begin
    frame_nxt = '0;
    for (int i = 0; i < N; i++) frame_nxt[i*SW +: SW] = shadow[i];
    frame_nxt[(N-1)*SW +: SW] = cap_data;
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N; i++) begin
      if (pipe_v[RL-1] && pipe_slot[RL-1] == CW'(i)) shadow[i] <= cap_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      cnt             <= '0;
      tick_pending    <= 1'b0;
      overrun_out     <= 1'b0;
      prefer_dbg      <= 1'b0;
      aux_dbg         <= 1'b0;
      addr_q          <= '0;
      osc_data_out    <= '0;
      frame_valid_out <= 1'b0;
      viz_valid_out   <= 1'b0;
      viz_data_out    <= '0;
      dbg_valid_out   <= 1'b0;
      dbg_data_out    <= '0;
      for (int i = 0; i < RL; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_on[i]   <= 1'b0;
        pipe_slot[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take_tick) tick_pending <= 1'b0;
      else if (sample_tick_in && !tick_drop) tick_pending <= 1'b1;
      if (tick_drop) overrun_out <= 1'b1;
      if (grant) begin
        aux_dbg    <= grant_dbg;
        prefer_dbg <= !grant_dbg;
      end
      if (bram_rd_en_out) addr_q <= cur_addr;
      pipe_v[0]    <= osc_issue;
      pipe_on[0]   <= osc_on;
      pipe_slot[0] <= cnt;
      for (int i = 1; i < RL; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_on[i]   <= pipe_on[i-1];
        pipe_slot[i] <= pipe_slot[i-1];
      end
      frame_valid_out <= publish;
      if (publish) osc_data_out <= frame_nxt;
      viz_valid_out <= aux_done && !aux_dbg;
      dbg_valid_out <= aux_done && aux_dbg;
      if (aux_done && !aux_dbg) viz_data_out <= bram_data_in;
      if (aux_done && aux_dbg) dbg_data_out <= bram_data_in;
    end
  end

endmodule

// File: tb/tb_wave_read_scheduler.sv
// Bench for wave_read_scheduler: schedule-level model plus directed vectors.
// BRAM stand-in returns addr+1000 with a two-cycle latency.
module tb_wave_read_scheduler;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int WW = 14;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_in = 1'b1;
  logic            sample_tick_in = 1'b0;
  logic [WW-1:0]   wave_width_in = 14'd1000;
  logic [N-1:0]    osc_is_on_in = 4'b1111;
  logic [N*WW-1:0] osc_index_in = {14'd40, 14'd30, 14'd20, 14'd10};
  logic [N*SW-1:0] osc_data_out;
  logic            frame_valid_out;
  logic            viz_req_in = 1'b0;
  logic [WW-1:0]   viz_index_in = '0;
  logic            viz_valid_out;
  logic [SW-1:0]   viz_data_out;
  logic            dbg_req_in = 1'b0;
  logic [WW-1:0]   dbg_index_in = '0;
  logic            dbg_valid_out;
  logic [SW-1:0]   dbg_data_out;
  logic [WW-1:0]   bram_addr_out;
  logic            bram_rd_en_out;
  logic [SW-1:0]   bram_data_in;
  logic            busy_out;
  logic            overrun_out;

  always #5 clk = ~clk;

  wave_read_scheduler #(
    .NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW),
    .WW_WIDTH(WW), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .sample_tick_in(sample_tick_in),
    .wave_width_in(wave_width_in),
    .osc_is_on_in(osc_is_on_in),
    .osc_index_in(osc_index_in),
    .osc_data_out(osc_data_out),
    .frame_valid_out(frame_valid_out),
    .viz_req_in(viz_req_in), .viz_index_in(viz_index_in),
    .viz_valid_out(viz_valid_out), .viz_data_out(viz_data_out),
    .dbg_req_in(dbg_req_in), .dbg_index_in(dbg_index_in),
    .dbg_valid_out(dbg_valid_out), .dbg_data_out(dbg_data_out),
    .bram_addr_out(bram_addr_out), .bram_rd_en_out(bram_rd_en_out),
    .bram_data_in(bram_data_in),
    .busy_out(busy_out), .overrun_out(overrun_out)
  );

  logic [WW-1:0] p1 = '0;
  logic [SW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= bram_addr_out;
    p2 <= {2'b00, p1} + 16'd1000;
  end
  assign bram_data_in = p2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Schedule model: a burst taken at T issues slot i at T+1+i and publishes
  // at T+N+RL+1; an aux grant at A reads at A+1 and answers at A+RL+2.
  int burst_t = -100;
  int aux_a = -100;
  bit aux_is_dbg = 0;
  int free_at = 0;
  bit pend = 0;
  bit m_ovr = 0;
  bit pref_dbg = 0;
  logic [SW-1:0]   m_slot [N];
  logic [SW-1:0]   m_aux = '0;
  logic [N*SW-1:0] m_osc = '0;
  logic [WW-1:0]   m_addr = '0;
  logic [SW-1:0]   m_viz = '0;
  logic [SW-1:0]   m_dbg = '0;

  initial begin
    int k, si;
    bit e_rd, e_fr, e_vv, e_dv, e_busy, idle, in_burst, drop, pick;
    logic [WW-1:0] a, ix;
    for (int i = 0; i < N; i++) m_slot[i] = '0;
    forever begin
      @(negedge clk);
      k = cyc;
      e_rd = 0;
      if (burst_t >= 0 && k >= burst_t + 1 && k <= burst_t + N) begin
        si = k - burst_t - 1;
        ix = osc_index_in[si*WW +: WW];
        a  = (ix >= wave_width_in) ? '0 : ix;
        if (osc_is_on_in[si]) begin
          e_rd = 1;
          m_addr = a;
          m_slot[si] = {2'b00, a} + 16'd1000;
        end else begin
          m_slot[si] = '0;
        end
      end
      if (aux_a >= 0 && k == aux_a + 1) begin
        a = aux_is_dbg ? dbg_index_in : viz_index_in;
        e_rd = 1;
        m_addr = a;
        m_aux = {2'b00, a} + 16'd1000;
      end
      e_fr = (burst_t >= 0 && k == burst_t + N + RL + 1);
      if (e_fr) for (int i = 0; i < N; i++) m_osc[i*SW +: SW] = m_slot[i];
      e_vv = (aux_a >= 0 && k == aux_a + RL + 2 && !aux_is_dbg);
      e_dv = (aux_a >= 0 && k == aux_a + RL + 2 && aux_is_dbg);
      if (e_vv) m_viz = m_aux;
      if (e_dv) m_dbg = m_aux;
      e_busy = (burst_t >= 0 && k >= burst_t + 1 && k <= burst_t + N + RL) ||
               (aux_a >= 0 && k >= aux_a + 1 && k <= aux_a + RL + 1);
      if (k >= 1) begin
        chk("m_rd_en", 64'(bram_rd_en_out), 64'(e_rd));
        chk("m_addr", 64'(bram_addr_out), 64'(m_addr));
        chk("m_frame_valid", 64'(frame_valid_out), 64'(e_fr));
        chk("m_osc_data", osc_data_out, m_osc);
        chk("m_viz_valid", 64'(viz_valid_out), 64'(e_vv));
        chk("m_viz_data", 64'(viz_data_out), 64'(m_viz));
        chk("m_dbg_valid", 64'(dbg_valid_out), 64'(e_dv));
        chk("m_dbg_data", 64'(dbg_data_out), 64'(m_dbg));
        chk("m_busy", 64'(busy_out), 64'(e_busy));
        chk("m_overrun", 64'(overrun_out), 64'(m_ovr));
      end
      if (rst_in) begin
        burst_t = -100; aux_a = -100; pend = 0; m_ovr = 0;
        pref_dbg = 0; free_at = k + 1;
        m_addr = '0; m_osc = '0; m_viz = '0; m_dbg = '0;
      end else begin
        idle = (k >= free_at);
        in_burst = (burst_t >= 0 && k >= burst_t + 1 &&
                    k <= burst_t + N + RL);
        drop = sample_tick_in && (pend || in_burst);
        if (drop) m_ovr = 1;
        if (idle) begin
          if (sample_tick_in || pend) begin
            burst_t = k;
            free_at = k + N + RL + 1;
            pend = 0;
          end else if (viz_req_in || dbg_req_in) begin
            pick = dbg_req_in && (!viz_req_in || pref_dbg);
            aux_a = k;
            aux_is_dbg = pick;
            pref_dbg = !pick;
            free_at = k + RL + 2;
          end
        end else if (sample_tick_in && !drop) begin
          pend = 1;
        end
      end
      cyc = k + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int x);
    while (cyc < x) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(output int t);
    step();
    sample_tick_in = 1'b1;
    t = cyc;
    step();
    sample_tick_in = 1'b0;
  endtask

  initial begin
    int t, a;
    repeat (3) step();
    rst_in = 1'b0;
    step();
    at_neg(cyc);
    chk("rst_osc_data", osc_data_out, 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_overrun", 64'(overrun_out), 64'd0);

    tick(t);
    at_neg(t + 1);
    chk("t1_addr0", 64'(bram_addr_out), 64'd10);
    chk("t1_rd0", 64'(bram_rd_en_out), 64'd1);
    at_neg(t + 4);
    chk("t1_addr3", 64'(bram_addr_out), 64'd40);
    at_neg(t + 7);
    chk("t1_frame", 64'(frame_valid_out), 64'd1);
    chk("t1_data", osc_data_out,
        {16'd1040, 16'd1030, 16'd1020, 16'd1010});

    step();
    osc_is_on_in = 4'b0101;
    tick(t);
    at_neg(t + 2);
    chk("t2_slot1_rd", 64'(bram_rd_en_out), 64'd0);
    at_neg(t + 7);
    chk("t2_frame", 64'(frame_valid_out), 64'd1);
    chk("t2_data", osc_data_out,
        {16'd0, 16'd1030, 16'd0, 16'd1010});
    step();
    osc_is_on_in = 4'b1111;

    step();
    viz_index_in = 14'd5;
    dbg_index_in = 14'd6;
    viz_req_in = 1'b1;
    dbg_req_in = 1'b1;
    a = cyc;
    at_neg(a + 4);
    chk("t3_viz_valid", 64'(viz_valid_out), 64'd1);
    chk("t3_viz_data", 64'(viz_data_out), 64'd1005);
    at_neg(a + 8);
    chk("t3_dbg_valid", 64'(dbg_valid_out), 64'd1);
    chk("t3_dbg_data", 64'(dbg_data_out), 64'd1006);
    at_neg(a + 11);
    step();
    viz_req_in = 1'b0;
    dbg_req_in = 1'b0;
    at_neg(a + 12);
    chk("t3_viz_again", 64'(viz_valid_out), 64'd1);

    step();
    viz_index_in = 14'd7;
    viz_req_in = 1'b1;
    a = cyc;
    step();
    step();
    sample_tick_in = 1'b1;
    step();
    sample_tick_in = 1'b0;
    step();
    viz_req_in = 1'b0;
    at_neg(a + 4);
    chk("t4_viz_valid", 64'(viz_valid_out), 64'd1);
    chk("t4_viz_data", 64'(viz_data_out), 64'd1007);
    at_neg(a + 5);
    chk("t4_burst_rd", 64'(bram_rd_en_out), 64'd1);
    at_neg(a + 11);
    chk("t4_frame", 64'(frame_valid_out), 64'd1);
    chk("t4_overrun", 64'(overrun_out), 64'd0);

    tick(t);
    step();
    step();
    sample_tick_in = 1'b1;
    step();
    sample_tick_in = 1'b0;
    at_neg(t + 4);
    chk("t5_overrun", 64'(overrun_out), 64'd1);
    at_neg(t + 7);
    chk("t5_frame", 64'(frame_valid_out), 64'd1);
    at_neg(t + 14);
    chk("t5_overrun_sticky", 64'(overrun_out), 64'd1);

    tick(t);
    step();
    step();
    step();
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    at_neg(t + 6);
    chk("t6_osc_zero", osc_data_out, 64'd0);
    chk("t6_overrun_zero", 64'(overrun_out), 64'd0);
    chk("t6_busy_zero", 64'(busy_out), 64'd0);
    at_neg(t + 7);
    chk("t6_no_frame", 64'(frame_valid_out), 64'd0);
    tick(t);
    at_neg(t + 7);
    chk("t6_frame_after", osc_data_out,
        {16'd1040, 16'd1030, 16'd1020, 16'd1010});

    step();
    wave_width_in = 14'd100;
    osc_index_in = {14'd40, 14'd30, 14'd99, 14'd100};
    tick(t);
    at_neg(t + 1);
    chk("t7_clamp_addr", 64'(bram_addr_out), 64'd0);
    chk("t7_clamp_rd", 64'(bram_rd_en_out), 64'd1);
    at_neg(t + 2);
    chk("t7_edge_addr", 64'(bram_addr_out), 64'd99);
    at_neg(t + 7);
    chk("t7_data", osc_data_out,
        {16'd1040, 16'd1030, 16'd1099, 16'd1000});

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
